// File: rtl/decrypt_v3_pkg.sv
// Shared widths, FSM encoding and PRESENT S-box tables for the iterative decryptor.
package decrypt_v3_pkg;

    localparam int N_K = 80;
    localparam int N_B = 64;
    localparam int NR  = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXPAND  = 2'd1,
        DECRYPT = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [3:0] SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    localparam logic [3:0] INV_SBOX [16] = '{
        4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
        4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
    };

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        return SBOX[x];
    endfunction

    function automatic logic [3:0] inv_sbox4(input logic [3:0] x);
        return INV_SBOX[x];
    endfunction

endpackage

// File: rtl/key_schedule.sv
// Forward PRESENT-80 key update: rotate left 61, S-box the top nibble, XOR round counter.
module key_schedule
    import decrypt_v3_pkg::*;
(
    output logic [N_K-1:0] r,
    input  logic [N_K-1:0] x,
    input  logic [4:0]     i
);

    logic [N_K-1:0] rot;

    assign rot = {x[18:0], x[79:19]};

    always_comb begin
        r          = rot;
        r[79:76]   = sbox4(rot[79:76]);
        r[19:15]   = rot[19:15] ^ i;
    end

endmodule

// File: rtl/key_schedule_inv.sv
// Inverse PRESENT-80 key update: undo the counter XOR and S-box, then rotate right 61.
module key_schedule_inv
    import decrypt_v3_pkg::*;
(
    output logic [N_K-1:0] r,
    input  logic [N_K-1:0] x,
    input  logic [4:0]     i
);

    logic [N_K-1:0] y;

    always_comb begin
        y          = x;
        y[19:15]   = x[19:15] ^ i;
        y[79:76]   = inv_sbox4(x[79:76]);
    end

    assign r = {y[60:0], y[79:61]};

endmodule

// File: rtl/decrypt_v3.sv
// Iterative PRESENT-80 decryptor: expands the key forward to K32, then unwinds one round per clock.
module decrypt_v3
    import decrypt_v3_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           req,
    input  logic [N_K-1:0] k,
    input  logic [N_B-1:0] c,
    output logic [N_B-1:0] m,
    output logic           ack
);

    state_t         state_reg, state_next;
    logic [N_K-1:0] kreg_reg;
    logic [N_B-1:0] sreg_reg;
    logic [4:0]     cnt_reg;
    logic [N_B-1:0] m_reg;

    logic [N_K-1:0] key_fwd;
    logic [N_K-1:0] key_inv;
    logic [N_B-1:0] perm_inv;
    logic [N_B-1:0] sub_inv;
    logic [N_B-1:0] round_out;

    key_schedule u_key_fwd (
        .r (key_fwd),
        .x (kreg_reg),
        .i (cnt_reg)
    );

    key_schedule_inv u_key_inv (
        .r (key_inv),
        .x (kreg_reg),
        .i (cnt_reg)
    );

    // P sends bit j to 16*j mod 63, so the inverse gathers each bit back from there.
    generate
        for (genvar gi = 0; gi < 63; gi++) begin : g_inv_perm
            assign perm_inv[gi] = sreg_reg[(16 * gi) % 63];
        end
    endgenerate
    assign perm_inv[63] = sreg_reg[63];

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_inv_sbox
            assign sub_inv[4*gi +: 4] = inv_sbox4(perm_inv[4*gi +: 4]);
        end
    endgenerate

    assign round_out = sub_inv ^ key_inv[79:16];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req)               state_next = EXPAND;
            EXPAND:  if (cnt_reg == 5'd31)  state_next = DECRYPT;
            DECRYPT: if (cnt_reg == 5'd1)   state_next = DONE;
            DONE:    if (!req)              state_next = IDLE;
            default:                        state_next = IDLE;
        endcase
    end

    always_comb begin
        ack = (state_reg == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kreg_reg <= '0;
            sreg_reg <= '0;
            cnt_reg  <= '0;
            m_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req) begin
                        kreg_reg <= k;
                        sreg_reg <= c;
                        cnt_reg  <= 5'd1;
                    end
                end
                EXPAND: begin
                    kreg_reg <= key_fwd;
                    // The last forward step yields K32, which whitens the ciphertext.
                    if (cnt_reg == 5'd31) begin
                        sreg_reg <= sreg_reg ^ key_fwd[79:16];
                    end else begin
                        cnt_reg <= cnt_reg + 5'd1;
                    end
                end
                DECRYPT: begin
                    kreg_reg <= key_inv;
                    sreg_reg <= round_out;
                    if (cnt_reg == 5'd1) begin
                        m_reg <= round_out;
                    end else begin
                        cnt_reg <= cnt_reg - 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m = m_reg;

endmodule

// File: tb/tb_decrypt_v3.sv
// Scoreboard bench for decrypt_v3: known-answer vectors plus handshake and reset corners.
module tb_decrypt_v3;

    logic        clk;
    logic        rst;
    logic        req;
    logic [79:0] k;
    logic [63:0] c;
    logic [63:0] m;
    logic        ack;

    int          checks;
    int          errors;
    logic [63:0] exp_q[$];
    logic        prev_ack;

    decrypt_v3 dut (
        .clk (clk),
        .rst (rst),
        .req (req),
        .k   (k),
        .c   (c),
        .m   (m),
        .ack (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Monitor: every rising ack presents one result, compared against the oldest expectation.
    initial prev_ack = 1'b0;
    always @(negedge clk) begin
        if (ack === 1'b1 && prev_ack !== 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got m=%h expected no result", m);
            end else begin
                check("result_m", {16'h0, m}, {16'h0, exp_q.pop_front()});
            end
        end
        prev_ack = ack;
    end

    // Issues one operation; waits for ack with a bounded budget, then exercises the release side.
    task automatic run_op(input logic [79:0] kk, input logic [63:0] cc, input logic [63:0] exp,
                          input bit drop_early, input bit toggle, input int hold);
        int n;
        @(negedge clk);
        k = kk;
        c = cc;
        req = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk);
        n = 1;
        #1;
        if (drop_early) req = 1'b0;
        while (1) begin
            @(posedge clk);
            n++;
            #1;
            if (toggle && n < 30) begin
                k = ~k;
                c = ~c;
            end
            if (ack === 1'b1 || n > 100) break;
        end
        if (ack !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: got no ack after %0d edges expected ack at edge 63", n);
            void'(exp_q.pop_back());
            req = 1'b0;
            return;
        end
        check("latency_edges", 80'(n), 80'd63);
        if (drop_early) begin
            @(posedge clk);
            #1;
            check("ack_one_cycle", {79'h0, ack}, 80'h0);
        end else begin
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                check("ack_held", {79'h0, ack}, 80'h1);
            end
            @(negedge clk);
            req = 1'b0;
            @(posedge clk);
            #1;
            check("ack_release", {79'h0, ack}, 80'h0);
        end
        check("m_retained", {16'h0, m}, {16'h0, exp});
        @(negedge clk);
    endtask

    initial begin
        int n;
        checks = 0;
        errors = 0;
        rst = 1'b0;
        req = 1'b0;
        k = '0;
        c = '0;
        #1;
        check("reset_ack", {79'h0, ack}, 80'h0);
        check("reset_m", {16'h0, m}, 80'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        run_op(80'h0, 64'h5579C1387B228445, 64'h0000000000000000, 1'b0, 1'b0, 0);
        run_op({80{1'b1}}, 64'hE72C46C0F5945049, 64'h0000000000000000, 1'b0, 1'b0, 4);
        run_op(80'h0, 64'hA112FFC72F68417B, 64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b0, 0);
        run_op({80{1'b1}}, 64'h3333DCD3213210D2, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b1, 1);

        // Abort an operation with an asynchronous reset shortly after edge 40.
        @(negedge clk);
        k = 80'h0;
        c = 64'h5579C1387B228445;
        req = 1'b1;
        exp_q.push_back(64'h0);
        @(posedge clk);
        n = 1;
        #1;
        req = 1'b0;
        while (n < 40) begin
            @(posedge clk);
            n++;
        end
        #2;
        rst = 1'b0;
        void'(exp_q.pop_back());
        #1;
        check("abort_ack", {79'h0, ack}, 80'h0);
        check("abort_m", {16'h0, m}, 80'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (70) begin
            @(posedge clk);
            #1;
            if (ack === 1'b1) break;
        end
        check("abort_no_ack", {79'h0, ack}, 80'h0);

        run_op(80'h0, 64'h5579C1387B228445, 64'h0000000000000000, 1'b0, 1'b0, 0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 80'(exp_q.size()), 80'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
